// File: rtl/picopsm_axi_arb.sv
// Round-robin AXI4-lite arbiter: several picopsm masters share one 16-bit-address,
// 8-bit-data downstream port, one complete read or write transaction at a time.
module picopsm_axi_arb #(
  parameter int NUM_MASTERS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_MASTERS-1:0]     m_awvalid,
  output logic [NUM_MASTERS-1:0]     m_awready,
  input  logic [16*NUM_MASTERS-1:0]  m_awaddr,
  input  logic [NUM_MASTERS-1:0]     m_wvalid,
  output logic [NUM_MASTERS-1:0]     m_wready,
  input  logic [8*NUM_MASTERS-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]     m_bvalid,
  input  logic [NUM_MASTERS-1:0]     m_bready,
  input  logic [NUM_MASTERS-1:0]     m_arvalid,
  output logic [NUM_MASTERS-1:0]     m_arready,
  input  logic [16*NUM_MASTERS-1:0]  m_araddr,
  output logic [NUM_MASTERS-1:0]     m_rvalid,
  input  logic [NUM_MASTERS-1:0]     m_rready,
  output logic [8*NUM_MASTERS-1:0]   m_rdata,
  output logic                       s_awvalid,
  input  logic                       s_awready,
  output logic [15:0]                s_awaddr,
  output logic [2:0]                 s_awprot,
  output logic                       s_wvalid,
  input  logic                       s_wready,
  output logic [7:0]                 s_wdata,
  input  logic                       s_bvalid,
  output logic                       s_bready,
  output logic                       s_arvalid,
  input  logic                       s_arready,
  output logic [15:0]                s_araddr,
  output logic [2:0]                 s_arprot,
  input  logic                       s_rvalid,
  output logic                       s_rready,
  input  logic [7:0]                 s_rdata,
  output logic [NUM_MASTERS-1:0]     grant,
  output logic                       busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_last, w_last_nxt;
  logic [IDX_W-1:0]       r_gidx, w_gidx_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic                   r_ar_done, w_ar_done_nxt;
  logic                   r_aw_done, w_aw_done_nxt;
  logic                   r_w_done, w_w_done_nxt;

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_found;
  logic [IDX_W-1:0]       w_pick;

  assign w_req = m_arvalid | m_awvalid | m_wvalid;
  assign grant = r_grant;
  assign busy  = (r_state != ST_IDLE);

  // Round-robin pick: first requester after the last winner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      int idx;
      idx = (int'(r_last) + k) % NUM_MASTERS;
      if (!w_found && w_req[idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end else begin
        w_found = w_found;
      end
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_last    <= IDX_W'(NUM_MASTERS - 1);
      r_gidx    <= '0;
      r_grant   <= '0;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_gidx    <= w_gidx_nxt;
      r_grant   <= w_grant_nxt;
      r_ar_done <= w_ar_done_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  // Next-state logic; done flags track which address/data beats already handshook.
  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_gidx_nxt    = r_gidx;
    w_grant_nxt   = r_grant;
    w_ar_done_nxt = r_ar_done;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt   = m_arvalid[w_pick] ? ST_RD : ST_WR;
          w_last_nxt    = w_pick;
          w_gidx_nxt    = w_pick;
          w_grant_nxt   = ONE_HOT0 << w_pick;
          w_ar_done_nxt = 1'b0;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        w_ar_done_nxt = r_ar_done | (s_arvalid & s_arready);
        if (s_rvalid && s_rready) begin
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = '0;
          w_ar_done_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_RD;
        end
      end
      ST_WR: begin
        w_aw_done_nxt = r_aw_done | (s_awvalid & s_awready);
        w_w_done_nxt  = r_w_done | (s_wvalid & s_wready);
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt = ST_WB;
        end else begin
          w_state_nxt = ST_WR;
        end
      end
      ST_WB: begin
        if (s_bvalid && s_bready) begin
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = '0;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Combinational forwarding between the granted master and the downstream port.
  always_comb begin
    s_awaddr  = m_awaddr[int'(r_gidx)*AW +: AW];
    s_araddr  = m_araddr[int'(r_gidx)*AW +: AW];
    s_wdata   = m_wdata[int'(r_gidx)*DW +: DW];
    s_awprot  = 3'b000;
    s_arprot  = 3'b000;
    m_rdata   = {NUM_MASTERS{s_rdata}};
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_arready = '0;
    m_rvalid  = '0;
    case (r_state)
      ST_RD: begin
        s_arvalid = m_arvalid[r_gidx] & ~r_ar_done;
        m_arready = r_grant & {NUM_MASTERS{s_arready & ~r_ar_done}};
        s_rready  = m_rready[r_gidx];
        m_rvalid  = r_grant & {NUM_MASTERS{s_rvalid}};
      end
      ST_WR: begin
        s_awvalid = m_awvalid[r_gidx] & ~r_aw_done;
        m_awready = r_grant & {NUM_MASTERS{s_awready & ~r_aw_done}};
        s_wvalid  = m_wvalid[r_gidx] & ~r_w_done;
        m_wready  = r_grant & {NUM_MASTERS{s_wready & ~r_w_done}};
      end
      ST_WB: begin
        s_bready = m_bready[r_gidx];
        m_bvalid = r_grant & {NUM_MASTERS{s_bvalid}};
      end
      default: begin
        s_bready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_picopsm_axi_arb.sv
// Directed self-checking bench for picopsm_axi_arb with two masters and a
// hand-driven downstream slave.
module tb_picopsm_axi_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_araddr;
  logic [15:0] m_wdata, m_rdata;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [15:0] s_awaddr, s_araddr;
  logic [2:0]  s_awprot, s_arprot;
  logic [7:0]  s_wdata, s_rdata;
  logic [1:0]  grant;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  picopsm_axi_arb #(.NUM_MASTERS(2)) dut (
    .clk(clk), .reset(reset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (grant == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n < 20), 32'd1);
  endtask

  // Full read for master m with a zero-wait slave.
  task automatic rd_txn(input int m, input logic [15:0] addr, input logic [7:0] data);
    logic [1:0] g;
    g = 2'b01 << m;
    wait_grant("rd_grant_wait");
    check_eq("rd_grant", 32'(grant), 32'(g));
    check_eq("rd_busy", 32'(busy), 32'd1);
    check_eq("rd_araddr", 32'(s_araddr), 32'(addr));
    check_eq("rd_arvalid", 32'(s_arvalid), 32'd1);
    check_eq("rd_awvalid_off", 32'(s_awvalid), 32'd0);
    s_arready = 1'b1;
    #1;
    check_eq("rd_arready_onehot", 32'(m_arready), 32'(g));
    tick();
    s_arready = 1'b0;
    m_arvalid[m] = 1'b0;
    s_rvalid = 1'b1;
    s_rdata  = data;
    #1;
    check_eq("rd_arvalid_done", 32'(s_arvalid), 32'd0);
    check_eq("rd_rvalid", 32'(m_rvalid), 32'(g));
    check_eq("rd_rdata", 32'(m_rdata), 32'({data, data}));
    m_rready[m] = 1'b1;
    #1;
    check_eq("rd_s_rready", 32'(s_rready), 32'd1);
    tick();
    s_rvalid = 1'b0;
    m_rready[m] = 1'b0;
    #1;
    check_eq("rd_release_grant", 32'(grant), 32'd0);
    check_eq("rd_release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 8'h00;
    tick();
    tick();
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_svalids", 32'({s_arvalid, s_awvalid, s_wvalid}), 32'd0);
    reset = 1'b0;
    tick();

    // Contention, twice: order must be 0,1,0,1.
    for (int rep = 0; rep < 2; rep++) begin
      m_araddr  = {16'h0201, 16'h0200};
      m_arvalid = 2'b11;
      rd_txn(0, 16'h0200, 8'h10);
      rd_txn(1, 16'h0201, 8'h21);
    end

    // Single read from master 1.
    m_araddr[31:16] = 16'h0100;
    m_arvalid[1] = 1'b1;
    rd_txn(1, 16'h0100, 8'hA5);

    // Split write: wready two cycles before awready.
    m_awaddr[15:0] = 16'h0020;
    m_wdata[7:0]   = 8'h3C;
    m_awvalid[0] = 1'b1;
    m_wvalid[0]  = 1'b1;
    wait_grant("wr_grant_wait");
    check_eq("wr_grant", 32'(grant), 32'd1);
    check_eq("wr_awvalid", 32'(s_awvalid), 32'd1);
    check_eq("wr_wvalid", 32'(s_wvalid), 32'd1);
    check_eq("wr_awaddr", 32'(s_awaddr), 32'h0020);
    check_eq("wr_wdata", 32'(s_wdata), 32'h3C);
    s_wready = 1'b1;
    #1;
    check_eq("wr_wready", 32'(m_wready), 32'd1);
    check_eq("wr_awready_low", 32'(m_awready), 32'd0);
    tick();
    s_wready = 1'b0;
    m_wvalid[0] = 1'b0;
    s_bvalid = 1'b1;
    #1;
    check_eq("wr_wvalid_done", 32'(s_wvalid), 32'd0);
    check_eq("wr_awvalid_held", 32'(s_awvalid), 32'd1);
    check_eq("wr_no_early_b", 32'(m_bvalid), 32'd0);
    tick();
    check_eq("wr_no_early_b2", 32'(m_bvalid), 32'd0);
    s_awready = 1'b1;
    #1;
    check_eq("wr_awready", 32'(m_awready), 32'd1);
    tick();
    s_awready = 1'b0;
    m_awvalid[0] = 1'b0;
    #1;
    check_eq("wb_bvalid", 32'(m_bvalid), 32'd1);
    check_eq("wb_awvalid_off", 32'(s_awvalid), 32'd0);
    m_bready[0] = 1'b1;
    #1;
    check_eq("wb_bready", 32'(s_bready), 32'd1);
    tick();
    s_bvalid = 1'b0;
    m_bready[0] = 1'b0;
    #1;
    check_eq("wb_release", 32'(grant), 32'd0);

    // Backpressure on master 1 while master 0 waits.
    m_araddr = {16'h1234, 16'h0055};
    m_arvalid[1] = 1'b1;
    wait_grant("bp_grant_wait");
    m_arvalid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_arvalid", 32'(s_arvalid), 32'd1);
      check_eq("bp_araddr", 32'(s_araddr), 32'h1234);
      check_eq("bp_grant", 32'(grant), 32'd2);
      tick();
    end
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    m_arvalid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_wait_r_grant", 32'(grant), 32'd2);
      check_eq("bp_wait_r_rvalid", 32'(m_rvalid), 32'd0);
      tick();
    end
    s_rvalid = 1'b1;
    s_rdata  = 8'h77;
    m_rready[1] = 1'b1;
    #1;
    check_eq("bp_rvalid", 32'(m_rvalid), 32'd2);
    tick();
    s_rvalid = 1'b0;
    m_rready[1] = 1'b0;
    #1;
    check_eq("bp_release", 32'(grant), 32'd0);
    rd_txn(0, 16'h0055, 8'h11);

    // Read wins over write for the same master; write follows.
    m_araddr[15:0] = 16'h0300;
    m_awaddr[15:0] = 16'h0310;
    m_wdata[7:0]   = 8'h5A;
    m_arvalid[0] = 1'b1;
    m_awvalid[0] = 1'b1;
    m_wvalid[0]  = 1'b1;
    tick();
    check_eq("row_rd_first", 32'({s_arvalid, s_awvalid, s_wvalid}), 32'b100);
    rd_txn(0, 16'h0300, 8'hC3);
    wait_grant("row_wr_wait");
    check_eq("row_wr_grant", 32'(grant), 32'd1);
    check_eq("row_awaddr", 32'(s_awaddr), 32'h0310);
    check_eq("row_wdata", 32'(s_wdata), 32'h5A);
    s_awready = 1'b1;
    s_wready  = 1'b1;
    tick();
    s_awready = 1'b0;
    s_wready  = 1'b0;
    m_awvalid[0] = 1'b0;
    m_wvalid[0]  = 1'b0;
    s_bvalid = 1'b1;
    #1;
    check_eq("row_same_cycle_wb", 32'(m_bvalid), 32'd1);
    m_bready[0] = 1'b1;
    tick();
    s_bvalid = 1'b0;
    m_bready[0] = 1'b0;
    #1;
    check_eq("row_release", 32'(grant), 32'd0);

    // Reset in the middle of a write with AW already accepted.
    m_awvalid[0] = 1'b1;
    m_wvalid[0]  = 1'b1;
    wait_grant("rst_wr_wait");
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    m_awvalid[0] = 1'b0;
    #1;
    check_eq("rst_wr_pre", 32'({s_awvalid, s_wvalid}), 32'b01);
    reset = 1'b1;
    #1;
    check_eq("rst_async_grant", 32'(grant), 32'd0);
    check_eq("rst_async_busy", 32'(busy), 32'd0);
    check_eq("rst_async_valids", 32'({s_awvalid, s_wvalid}), 32'd0);
    m_wvalid = '0;
    #1;
    reset = 1'b0;
    m_araddr  = {16'h0401, 16'h0400};
    m_arvalid = 2'b11;
    rd_txn(0, 16'h0400, 8'h40);
    rd_txn(1, 16'h0401, 8'h41);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/picopsm_axi_arb.md
# picopsm_axi_arb

Round-robin AXI4-lite arbiter that lets several picopsm cores share one 16-bit-address, 8-bit-data memory/peripheral port. Each core's AXI4-lite master interface connects to one upstream port; the single downstream port drives the shared memory. One complete transaction is in flight at a time: read AR→R or write AW+W→B. Grant is held until the response handshake completes.

## Interface
- NUM_MASTERS, 2, number of upstream ports (2..8); port i uses slice [i] or [i*W +: W] of each vector
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- m_awvalid / m_awready  in / out  NUM_MASTERS  per-master write-address handshake
- m_awaddr  in  16*NUM_MASTERS  per-master write address
- m_wvalid / m_wready  in / out  NUM_MASTERS  per-master write-data handshake
- m_wdata  in  8*NUM_MASTERS  per-master write data
- m_bvalid / m_bready  out / in  NUM_MASTERS  per-master write response
- m_arvalid / m_arready  in / out  NUM_MASTERS  per-master read-address handshake
- m_araddr  in  16*NUM_MASTERS  per-master read address
- m_rvalid / m_rready  out / in  NUM_MASTERS  per-master read response
- m_rdata  out  8*NUM_MASTERS  read data, same byte broadcast to all slices
- s_awvalid, s_awready, s_awaddr[15:0], s_awprot[2:0], s_wvalid, s_wready, s_wdata[7:0], s_bvalid, s_bready, s_arvalid, s_arready, s_araddr[15:0], s_arprot[2:0], s_rvalid, s_rready, s_rdata[7:0]  downstream AXI4-lite master, usual directions; s_awprot = s_arprot = 0
- grant  out  NUM_MASTERS  one-hot owner of the downstream port, 0 when idle
- busy  out  1  transaction in flight

## Operation
- States: IDLE, RD (AR/R phase), WR (AW/W phase), WB (B phase).
- Request of master i: m_arvalid[i] | m_awvalid[i] | m_wvalid[i].
- IDLE: if any request, grant the first requester searching from (last+1) mod NUM_MASTERS upward with wrap; record it in last. If that master has arvalid go RD, else go WR (read wins if both asserted). No request: stay IDLE, last unchanged.
- Forwarding only for the granted master g; all m_*ready, m_bvalid, m_rvalid of non-granted masters are 0.
- RD: s_arvalid = m_arvalid[g] & ~ar_done, s_araddr = m_araddr[g], m_arready[g] = s_arready & ~ar_done; ar_done set on AR handshake. s_rready = m_rready[g], m_rvalid[g] = s_rvalid. On R handshake → IDLE, grant cleared.
- WR: AW and W forwarded independently with aw_done/w_done flags exactly as in RD; the two may complete in either order or the same cycle. When both done (including same-cycle completion) → WB.
- WB: s_bready = m_bready[g], m_bvalid[g] = s_bvalid; on B handshake → IDLE.
- Data, address and response are combinational pass-through; no buffering, no reordering, no response checking (bresp/rresp not carried).
- Masters must hold valid/address stable until handshake (AXI rule); arbiter does not latch them.

## Timing
- Reset values: grant=0, busy=0, state IDLE, last=NUM_MASTERS-1 (master 0 first after reset), all s_*valid/s_*ready and m_*ready/m_*valid = 0, done flags 0.
- Arbitration latency: request sampled in IDLE at edge N → grant/busy high and s_arvalid/s_awvalid forwarded from cycle N+1.
- Release: response handshake at edge M → grant=0 in cycle M+1; next grant earliest at edge M+1, visible M+2. Minimum 1 idle cycle between transactions; back-to-back requester sees 3-cycle minimum per transaction with zero-wait slave.
- Fairness: with all masters continuously requesting, grants rotate 0,1,...,N-1,0; no master waits more than NUM_MASTERS-1 transactions.
- Request withdrawn before grant: no effect (illegal per AXI but harmless). Request arriving while busy: waits, no loss.
- Reset asserted mid-transaction: all outputs drop immediately (async); downstream transaction abandoned—reset is system-wide by design.

## Test plan
- Single read: master 1 arvalid, araddr=0x0100, slave arready immediate, rdata=0xA5 one cycle later → grant=2'b10 next cycle, s_araddr=0x0100, m_rvalid[1] with m_rdata=0xA5, grant 0 after R handshake.
- Contention: both masters assert arvalid at same edge after reset → master 0 served first, then master 1; repeat with both → order 0,1,0,1; m_arready[1] never high while grant=2'b01.
- Split write: master 0 awaddr=0x0020, wdata=0x3C; slave asserts wready 2 cycles before awready → single s_awvalid handshake, single s_wvalid handshake, WB entered only after both, m_bvalid[0] on s_bvalid.
- Backpressure: slave holds arready low 5 cycles, rvalid 3 cycles later → s_arvalid and s_araddr stable throughout, grant held until R handshake, competing master's request served afterward.
- Read-over-write: master 0 asserts arvalid and awvalid simultaneously → RD entered first, write follows after next arbitration (master 1 idle).
- Reset mid-write: assert reset during WR with aw_done=1 → grant, busy, s_awvalid, s_wvalid all 0 without clock edge; after release, master 0 granted first.
